// File: rtl/upower_exec_unit.sv
// upower_exec_unit: execute stage of the 64-bit uPOWER pipeline.
// Main control decode, ALU-control decode, operand-B mux and a 64-bit ALU,
// all captured in an EX/MEM register (1-cycle latency).
// Optional build macro: UPWR_EXEC_BRANCH_TARGET_EN adds pc_in/branch_target.
module upower_exec_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] ra_data,
  input  logic [XLEN-1:0] rb_data,
  input  logic            stall,
  input  logic            flush,
`ifdef UPWR_EXEC_BRANCH_TARGET_EN
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] branch_target,
`endif
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            overflow,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      write_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            jump,
  output logic            branch_taken,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NAND = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  logic [5:0]      opcode_s;
  logic [8:0]      xo_s;
  logic [15:0]     imm_s;
  logic            reg_dst_s, alu_src_s, reg_write_s, mem_read_s, mem_write_s;
  logic            mem_to_reg_s, branch_s, jump_s, sign_zero_s, bad_op_s, bad_xo_s;
  logic [1:0]      alu_op_s;
  logic [3:0]      alu_ctrl_s;
  logic [XLEN-1:0] imm_ext_s, op_b_s, alu_res_s;
  logic            ovf_s, zero_s, live_s, illegal_s;
  logic            unused_s;

  assign opcode_s  = instr[31:26];
  assign xo_s      = instr[9:1];
  assign imm_s     = instr[15:0];
  assign unused_s  = ^{instr[10], instr[0]};
  assign live_s    = in_valid & ~flush;
  assign illegal_s = bad_op_s | bad_xo_s;

  // Main control decode from the primary opcode.
  always_comb begin
    reg_dst_s    = 1'b0;
    alu_src_s    = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    sign_zero_s  = 1'b0;
    bad_op_s     = 1'b0;
    alu_op_s     = 2'b00;
    case (opcode_s)
      6'd31: begin reg_dst_s = 1'b1; reg_write_s = 1'b1; alu_op_s = 2'b10; end
      6'd14: begin alu_src_s = 1'b1; reg_write_s = 1'b1; end
      6'd28, 6'd24, 6'd26: begin
        alu_src_s = 1'b1; reg_write_s = 1'b1; alu_op_s = 2'b11; sign_zero_s = 1'b1;
      end
      6'd58: begin
        alu_src_s = 1'b1; reg_write_s = 1'b1; mem_read_s = 1'b1; mem_to_reg_s = 1'b1;
      end
      6'd62: begin alu_src_s = 1'b1; mem_write_s = 1'b1; end
      6'd19: begin branch_s = 1'b1; alu_op_s = 2'b01; end
      6'd18: begin jump_s = 1'b1; end
      default: bad_op_s = 1'b1;
    endcase
  end

  // ALU-control decode; an unknown opcode also forces the invalid code so it yields 0.
  always_comb begin
    alu_ctrl_s = ALU_INV;
    bad_xo_s   = 1'b0;
    if (bad_op_s) begin
      alu_ctrl_s = ALU_INV;
    end else begin
      case (alu_op_s)
        2'b00: alu_ctrl_s = ALU_ADD;
        2'b01: alu_ctrl_s = ALU_SUB;
        2'b11: begin
          case (opcode_s)
            6'd28:   alu_ctrl_s = ALU_AND;
            6'd24:   alu_ctrl_s = ALU_OR;
            6'd26:   alu_ctrl_s = ALU_XOR;
            default: alu_ctrl_s = ALU_INV;
          endcase
        end
        2'b10: begin
          case (xo_s)
            9'd266:  alu_ctrl_s = ALU_ADD;
            9'd40:   alu_ctrl_s = ALU_SUB;
            9'd28:   alu_ctrl_s = ALU_AND;
            9'd444:  alu_ctrl_s = ALU_OR;
            9'd316:  alu_ctrl_s = ALU_XOR;
            9'd476:  alu_ctrl_s = ALU_NAND;
            9'd124:  alu_ctrl_s = ALU_NOR;
            9'd0:    alu_ctrl_s = ALU_SLT;
            default: begin alu_ctrl_s = ALU_INV; bad_xo_s = 1'b1; end
          endcase
        end
        default: alu_ctrl_s = ALU_INV;
      endcase
    end
  end

  // Operand B: register, or the 16-bit immediate sign/zero-extended.
  always_comb begin
    if (sign_zero_s) begin
      imm_ext_s = {{(XLEN-16){1'b0}}, imm_s};
    end else begin
      imm_ext_s = {{(XLEN-16){imm_s[15]}}, imm_s};
    end
    if (alu_src_s) begin
      op_b_s = imm_ext_s;
    end else begin
      op_b_s = rb_data;
    end
  end

  // 64-bit ALU with signed overflow for ADD/SUB only.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    ovf_s     = 1'b0;
    case (alu_ctrl_s)
      ALU_AND:  alu_res_s = ra_data & op_b_s;
      ALU_OR:   alu_res_s = ra_data | op_b_s;
      ALU_XOR:  alu_res_s = ra_data ^ op_b_s;
      ALU_NAND: alu_res_s = ~(ra_data & op_b_s);
      ALU_NOR:  alu_res_s = ~(ra_data | op_b_s);
      ALU_ADD: begin
        alu_res_s = ra_data + op_b_s;
        ovf_s = (ra_data[XLEN-1] == op_b_s[XLEN-1]) && (alu_res_s[XLEN-1] != ra_data[XLEN-1]);
      end
      ALU_SUB: begin
        alu_res_s = ra_data - op_b_s;
        ovf_s = (ra_data[XLEN-1] != op_b_s[XLEN-1]) && (alu_res_s[XLEN-1] != ra_data[XLEN-1]);
      end
      ALU_SLT: begin
        if ($signed(ra_data) < $signed(op_b_s)) begin
          alu_res_s = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          alu_res_s = {XLEN{1'b0}};
        end
      end
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  assign zero_s = (alu_res_s == {XLEN{1'b0}});

  // EX/MEM register: flush overrides stall; killed slots drop their side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      alu_result   <= {XLEN{1'b0}};
      zero         <= 1'b0;
      overflow     <= 1'b0;
      store_data   <= {XLEN{1'b0}};
      write_reg    <= 5'd0;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_to_reg   <= 1'b0;
      jump         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush || !stall) begin
      out_valid    <= live_s;
      alu_result   <= alu_res_s;
      zero         <= zero_s;
      overflow     <= ovf_s;
      store_data   <= rb_data;
      write_reg    <= reg_dst_s ? instr[15:11] : instr[20:16];
      reg_write    <= live_s & reg_write_s & ~bad_xo_s;
      mem_read     <= live_s & mem_read_s;
      mem_write    <= live_s & mem_write_s;
      mem_to_reg   <= mem_to_reg_s;
      jump         <= live_s & jump_s;
      branch_taken <= live_s & branch_s & zero_s;
      illegal      <= live_s & illegal_s;
    end
  end

`ifdef UPWR_EXEC_BRANCH_TARGET_EN
  logic [XLEN-1:0] branch_target_s;
  assign branch_target_s = pc_in + {{(XLEN-3){1'b0}}, 3'd4}
                         + ({{(XLEN-16){imm_s[15]}}, imm_s} << 2);

  // Branch target register, same load/hold rules as the data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_target <= {XLEN{1'b0}};
    end else if (flush || !stall) begin
      branch_target <= branch_target_s;
    end
  end
`endif

endmodule

// File: tb/tb_upower_exec_unit.sv
// Self-checking bench for upower_exec_unit (default build): vector table plus
// hand-written stall/flush/reset sequences.
module tb_upower_exec_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr;
  logic [63:0] ra_data, rb_data;
  logic        out_valid, zero, overflow;
  logic [63:0] alu_result, store_data;
  logic [4:0]  write_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg, jump, branch_taken, illegal;

  int nerr = 0;
  int nchk = 0;

  upower_exec_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .ra_data(ra_data), .rb_data(rb_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero), .overflow(overflow),
    .store_data(store_data), .write_reg(write_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .jump(jump), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] res;
    logic        zero;
    logic        ov;
    logic [4:0]  wr;
    logic [6:0]  ctrl;  // {reg_write, mem_read, mem_write, mem_to_reg, jump, branch_taken, illegal}
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] xf(input logic [8:0] xo);
    return {6'd31, 5'd1, 5'd2, 5'd3, 1'b0, xo, 1'b0};
  endfunction

  function automatic logic [31:0] df(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd4, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] r, input logic z, input logic o,
                              input logic [4:0] w, input logic [6:0] c);
    vec_t v;
    v.instr = i; v.ra = a; v.rb = b; v.res = r; v.zero = z; v.ov = o; v.wr = w; v.ctrl = c;
    return v;
  endfunction

  function automatic logic [63:0] ctrl_now();
    return {57'd0, reg_write, mem_read, mem_write, mem_to_reg, jump, branch_taken, illegal};
  endfunction

  function automatic logic [63:0] misc_now();
    return {49'd0, out_valid, zero, overflow, write_reg, reg_write, mem_read, mem_write,
            mem_to_reg, jump, branch_taken, illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] a,
                       input logic [63:0] b, input logic s, input logic f);
    in_valid = v; instr = i; ra_data = a; rb_data = b; stall = s; flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: instr, ra, rb, result, zero, overflow, write_reg, ctrl
    vecs.push_back(mk(xf(9'd266), 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(df(6'd14, 16'hFFFF), 64'd10, 64'd0, 64'd9, 1'b0, 1'b0, 5'd4, 7'b1000000));
    vecs.push_back(mk(df(6'd28, 16'hFFFF), 64'h12345, 64'd0, 64'h2345, 1'b0, 1'b0, 5'd4, 7'b1000000));
    vecs.push_back(mk(df(6'd24, 16'h00F0), 64'h0F, 64'd0, 64'hFF, 1'b0, 1'b0, 5'd4, 7'b1000000));
    vecs.push_back(mk(df(6'd26, 16'hFFFF), 64'h00FF, 64'd0, 64'hFF00, 1'b0, 1'b0, 5'd4, 7'b1000000));
    vecs.push_back(mk(xf(9'd40), MINN, 64'd1, MAXP, 1'b0, 1'b1, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd266), MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd266), MINN, MINN, 64'd0, 1'b1, 1'b1, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd28), 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd444), 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd316), 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd476), ONES, ONES, 64'd0, 1'b1, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd124), 64'd0, 64'd0, ONES, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd0), ONES, 64'd1, 64'd1, 1'b0, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(xf(9'd0), 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b1, 1'b0, 5'd3, 7'b1000000));
    vecs.push_back(mk(df(6'd58, 16'h0010), 64'h1000, 64'd0, 64'h1010, 1'b0, 1'b0, 5'd4, 7'b1101000));
    vecs.push_back(mk(df(6'd62, 16'hFFF8), 64'h1000, 64'hDEAD, 64'h0FF8, 1'b0, 1'b0, 5'd4, 7'b0010000));
    vecs.push_back(mk(df(6'd19, 16'h0004), 64'd3, 64'd3, 64'd0, 1'b1, 1'b0, 5'd4, 7'b0000010));
    vecs.push_back(mk(df(6'd19, 16'h0004), 64'd3, 64'd4, ONES, 1'b0, 1'b0, 5'd4, 7'b0000000));
    vecs.push_back(mk(df(6'd18, 16'h0100), 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 5'd4, 7'b0000100));
    vecs.push_back(mk(xf(9'd5), 64'd1, 64'd2, 64'd0, 1'b1, 1'b0, 5'd3, 7'b0000001));
    vecs.push_back(mk(df(6'd0, 16'h1234), 64'd1, 64'd2, 64'd0, 1'b1, 1'b0, 5'd4, 7'b0000001));

    // Reset state
    reset = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #12;
    chk("reset alu_result", alu_result, 64'd0);
    chk("reset store_data", store_data, 64'd0);
    chk("reset misc", misc_now(), 64'd0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].ra, vecs[i].rb, 1'b0, 1'b0);
      step();
      chk($sformatf("v%0d alu_result", i), alu_result, vecs[i].res);
      chk($sformatf("v%0d zero_ovf", i), {62'd0, zero, overflow}, {62'd0, vecs[i].zero, vecs[i].ov});
      chk($sformatf("v%0d write_reg", i), {59'd0, write_reg}, {59'd0, vecs[i].wr});
      chk($sformatf("v%0d ctrl", i), ctrl_now(), {57'd0, vecs[i].ctrl});
      chk($sformatf("v%0d store_data", i), store_data, vecs[i].rb);
      chk($sformatf("v%0d out_valid", i), {63'd0, out_valid}, 64'd1);
    end

    // Stall for two cycles: outputs hold the earlier add
    drive(1'b1, xf(9'd266), 64'd5, 64'd7, 1'b0, 1'b0);
    step();
    chk("pre-stall alu_result", alu_result, 64'd12);
    drive(1'b1, df(6'd14, 16'hFFFF), 64'd10, 64'd99, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("stall%0d alu_result", c), alu_result, 64'd12);
      chk($sformatf("stall%0d store_data", c), store_data, 64'd7);
      chk($sformatf("stall%0d misc", c), misc_now(), {49'd0, 15'b1_0_0_00011_1000000});
    end
    stall = 1'b0;
    step();
    chk("post-stall alu_result", alu_result, 64'd9);

    // Stall together with flush: killed slot, no reg_write
    drive(1'b1, xf(9'd266), 64'd5, 64'd7, 1'b1, 1'b1);
    step();
    chk("stall+flush valid_rw", {62'd0, out_valid, reg_write}, 64'd0);

    // Flush alone on a taken beq: no branch_taken, data still loads
    drive(1'b1, df(6'd19, 16'h0004), 64'd3, 64'd3, 1'b0, 1'b1);
    step();
    chk("flush beq ctrl", {62'd0, out_valid, branch_taken}, 64'd0);
    chk("flush beq zero", {63'd0, zero}, 64'd1);

    // in_valid low: controls cleared, data loads
    drive(1'b0, xf(9'd266), 64'd1, 64'd1, 1'b0, 1'b0);
    step();
    chk("invalid ctrl", {62'd0, out_valid, reg_write}, 64'd0);
    chk("invalid alu_result", alu_result, 64'd2);

    // Asynchronous reset mid-cycle while stalled
    drive(1'b1, xf(9'd266), 64'd5, 64'd7, 1'b0, 1'b0);
    step();
    chk("pre-reset alu_result", alu_result, 64'd12);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async reset alu_result", alu_result, 64'd0);
    chk("async reset store_data", store_data, 64'd0);
    chk("async reset misc", misc_now(), 64'd0);
    #1 reset = 1'b0;
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
